// File: rtl/elevator_pkg.sv
// Shared elevator encodings: travel directions, door and switch levels,
// floor sizing and the car motion FSM states.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 7;
    localparam int unsigned FLOOR_W    = 3;

    typedef enum logic [1:0] {
        STOP   = 2'b00,
        DOWN   = 2'b01,
        UP     = 2'b10,
        UPDOWN = 2'b11
    } dir_e;

    localparam logic OPEN  = 1'b1;
    localparam logic CLOSE = 1'b0;
    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MOVING = 2'b01,
        ARRIVE = 2'b10,
        DWELL  = 2'b11
    } state_e;

    function automatic dir_e opp_dir(input dir_e d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            default: return STOP;
        endcase
    endfunction

endpackage

// File: rtl/request_scan.sv
// Flags whether any request lies strictly above or strictly below a floor.
module request_scan
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS:1] i_req,
    input  logic [FLOOR_W-1:0]  i_floor,
    output logic                o_ahead_up,
    output logic                o_ahead_down
);

    always_comb begin
        o_ahead_up   = 1'b0;
        o_ahead_down = 1'b0;
        for (int k = 1; k <= int'(NUM_FLOORS); k++) begin
            if (i_req[k] && (k > int'(i_floor))) o_ahead_up = 1'b1;
            if (i_req[k] && (k < int'(i_floor))) o_ahead_down = 1'b1;
        end
    end

endmodule

// File: rtl/car_motion_ctrl.sv
// Elevator car motion controller: SCAN floor selection, travel timing, dwell
// with closed-door interlock, and a one-cycle served strobe for the button latch.
module car_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned CLK_PER_FLOOR = 100000000,
    parameter int unsigned MIN_DWELL     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                doorState,
    input  logic [NUM_FLOORS:1] upButton,
    input  logic [NUM_FLOORS:1] downButton,
    input  logic [NUM_FLOORS:1] carButton,
    output logic [FLOOR_W-1:0]  currentFloor,
    output logic [1:0]          currentDirection,
    output logic [1:0]          currentFloorButton,
    output logic                moving,
    output logic                servedValid,
    output logic [FLOOR_W-1:0]  servedFloor,
    output logic [1:0]          servedDirection
);

    localparam int unsigned TRAVEL_W = $clog2(CLK_PER_FLOOR);
    localparam int unsigned DWELL_W  = $clog2(MIN_DWELL);
    localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(CLK_PER_FLOOR - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LOAD  = DWELL_W'(MIN_DWELL - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0]  BOT_FLOOR   = FLOOR_W'(1);

    state_e                r_state;
    dir_e                  r_dir;
    dir_e                  r_served_dir;
    logic [FLOOR_W-1:0]    r_floor;
    logic [FLOOR_W-1:0]    r_served_floor;
    logic                  r_moving;
    logic                  r_served_valid;
    logic [TRAVEL_W-1:0]   r_travel_cnt;
    logic [DWELL_W-1:0]    r_dwell_cnt;

    logic [NUM_FLOORS:1]   w_up;
    logic [NUM_FLOORS:1]   w_down;
    logic [NUM_FLOORS:0]   w_up_v;
    logic [NUM_FLOORS:0]   w_down_v;
    logic [NUM_FLOORS:0]   w_car_v;
    logic                  w_ahead_up;
    logic                  w_ahead_down;
    logic                  w_ahead_d;
    logic                  w_ahead_opp;
    logic                  w_hall_d_f;
    logic                  w_hall_opp_f;
    logic                  w_car_f;

    // No hall-up call exists at the top floor, nor hall-down at the bottom.
    assign w_up     = upButton & {1'b0, {(NUM_FLOORS - 1){1'b1}}};
    assign w_down   = downButton & {{(NUM_FLOORS - 1){1'b1}}, 1'b0};
    assign w_up_v   = {w_up, 1'b0};
    assign w_down_v = {w_down, 1'b0};
    assign w_car_v  = {carButton, 1'b0};
    assign w_car_f  = w_car_v[r_floor];

    request_scan u_request_scan (
        .i_req       (w_up | w_down | carButton),
        .i_floor     (r_floor),
        .o_ahead_up  (w_ahead_up),
        .o_ahead_down(w_ahead_down)
    );

    always_comb begin
        w_ahead_d    = 1'b0;
        w_ahead_opp  = 1'b0;
        w_hall_d_f   = 1'b0;
        w_hall_opp_f = 1'b0;
        case (r_dir)
            UP: begin
                w_ahead_d    = w_ahead_up;
                w_ahead_opp  = w_ahead_down;
                w_hall_d_f   = w_up_v[r_floor];
                w_hall_opp_f = w_down_v[r_floor];
            end
            DOWN: begin
                w_ahead_d    = w_ahead_down;
                w_ahead_opp  = w_ahead_up;
                w_hall_d_f   = w_down_v[r_floor];
                w_hall_opp_f = w_up_v[r_floor];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_dir          <= STOP;
            r_floor        <= BOT_FLOOR;
            r_moving       <= 1'b0;
            r_served_valid <= 1'b0;
            r_served_floor <= BOT_FLOOR;
            r_served_dir   <= STOP;
            r_travel_cnt   <= '0;
            r_dwell_cnt    <= '0;
        end else if (enable) begin
            r_served_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (doorState == CLOSE) begin
                        if (w_car_f || w_up_v[r_floor] || w_down_v[r_floor]) begin
                            r_dir          <= (w_car_f || w_up_v[r_floor]) ? UP : DOWN;
                            r_served_dir   <= (w_car_f || w_up_v[r_floor]) ? UP : DOWN;
                            r_state        <= DWELL;
                            r_dwell_cnt    <= DWELL_LOAD;
                            r_served_valid <= 1'b1;
                            r_served_floor <= r_floor;
                        end else if (w_ahead_up || w_ahead_down) begin
                            r_dir        <= w_ahead_up ? UP : DOWN;
                            r_state      <= MOVING;
                            r_travel_cnt <= TRAVEL_LOAD;
                            r_moving     <= 1'b1;
                        end
                    end
                end
                MOVING: begin
                    if (r_travel_cnt == '0) begin
                        r_state <= ARRIVE;
                        if (r_dir == UP && r_floor < TOP_FLOOR) begin
                            r_floor <= r_floor + 1'b1;
                        end else if (r_dir == DOWN && r_floor > BOT_FLOOR) begin
                            r_floor <= r_floor - 1'b1;
                        end
                    end else begin
                        r_travel_cnt <= r_travel_cnt - 1'b1;
                    end
                end
                ARRIVE: begin
                    if (w_car_f || w_hall_d_f || !w_ahead_d) begin
                        r_state        <= DWELL;
                        r_dwell_cnt    <= DWELL_LOAD;
                        r_moving       <= 1'b0;
                        r_served_valid <= 1'b1;
                        r_served_floor <= r_floor;
                        // End of the run with only an opposite hall call: turn around here.
                        if (!w_car_f && !w_hall_d_f && w_hall_opp_f) begin
                            r_dir        <= opp_dir(r_dir);
                            r_served_dir <= opp_dir(r_dir);
                        end else begin
                            r_served_dir <= r_dir;
                        end
                    end else begin
                        r_state      <= MOVING;
                        r_travel_cnt <= TRAVEL_LOAD;
                    end
                end
                DWELL: begin
                    if (r_dwell_cnt != '0) begin
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                    end else if (doorState == CLOSE) begin
                        if (w_ahead_d || (!w_hall_opp_f && w_ahead_opp)) begin
                            r_dir        <= w_ahead_d ? r_dir : opp_dir(r_dir);
                            r_state      <= MOVING;
                            r_travel_cnt <= TRAVEL_LOAD;
                            r_moving     <= 1'b1;
                        end else if (w_hall_opp_f) begin
                            r_dir          <= opp_dir(r_dir);
                            r_served_dir   <= opp_dir(r_dir);
                            r_dwell_cnt    <= DWELL_LOAD;
                            r_served_valid <= 1'b1;
                            r_served_floor <= r_floor;
                        end else begin
                            r_dir   <= STOP;
                            r_state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign currentFloor       = r_floor;
    assign currentDirection   = r_dir;
    assign currentFloorButton = {w_up_v[r_floor], w_down_v[r_floor]};
    assign moving             = r_moving;
    assign servedValid        = r_served_valid & enable;
    assign servedFloor        = r_served_floor;
    assign servedDirection    = r_served_dir;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Scoreboard bench for car_motion_ctrl: an event-level SCAN model predicts each
// served strobe (floor, direction, cycle); a monitor pops and compares them.
module tb_car_motion_ctrl;

    localparam int CPF = 4;
    localparam int MD  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       doorState;
    logic [7:1] upButton;
    logic [7:1] downButton;
    logic [7:1] carButton;
    logic [2:0] currentFloor;
    logic [1:0] currentDirection;
    logic [1:0] currentFloorButton;
    logic       moving;
    logic       servedValid;
    logic [2:0] servedFloor;
    logic [1:0] servedDirection;

    car_motion_ctrl #(
        .CLK_PER_FLOOR(CPF),
        .MIN_DWELL    (MD)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .doorState         (doorState),
        .upButton          (upButton),
        .downButton        (downButton),
        .carButton         (carButton),
        .currentFloor      (currentFloor),
        .currentDirection  (currentDirection),
        .currentFloorButton(currentFloorButton),
        .moving            (moving),
        .servedValid       (servedValid),
        .servedFloor       (servedFloor),
        .servedDirection   (servedDirection)
    );

    always #5 clk = ~clk;

    typedef struct {
        int floor;
        int dir;
        int cyc;
        bit timed;
    } ev_t;

    ev_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  m_floor = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] enc(input int d);
        if (d > 0) return 2'b10;
        if (d < 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit any_above(input logic [7:0] r, input int f);
        for (int k = f + 1; k <= 7; k++) if (r[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input logic [7:0] r, input int f);
        for (int k = 1; k < f; k++) if (r[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Walks the SCAN rules over a fixed request set, predicting every served event.
    // t is the cycle of the most recent decision point; each floor costs CPF+1 cycles.
    task automatic model_round(input logic [7:0] c0, input logic [7:0] u0,
                               input logic [7:0] d0, input int base, input bit timed);
        logic [7:0] c = c0;
        logic [7:0] u = u0;
        logic [7:0] dn = d0;
        logic [7:0] all, hd, ho;
        int f = m_floor;
        int d = 0;
        int n = 0;
        int t = base;
        int phase = 0;
        int guard = 0;
        bit ahd, aho;
        while (phase != 3 && guard < 64) begin
            guard++;
            all = c | u | dn;
            case (phase)
                0: begin
                    n = 0;
                    if (c[f] || u[f]) begin d = 1; phase = 2; end
                    else if (dn[f]) begin d = -1; phase = 2; end
                    else if (any_above(all, f)) begin d = 1; phase = 1; end
                    else if (any_below(all, f)) begin d = -1; phase = 1; end
                    else phase = 3;
                end
                1: begin
                    f = f + d;
                    n++;
                    hd  = (d > 0) ? u : dn;
                    ho  = (d > 0) ? dn : u;
                    ahd = (d > 0) ? any_above(all, f) : any_below(all, f);
                    if (c[f] || hd[f] || !ahd) begin
                        if (!c[f] && !hd[f] && ho[f]) d = -d;
                        phase = 2;
                    end
                end
                default: begin
                    t = t + 1 + (CPF + 1) * n;
                    sb.push_back('{f, d, t, timed});
                    c[f] = 1'b0;
                    if (d > 0) u[f] = 1'b0;
                    else dn[f] = 1'b0;
                    t = t + (MD - 1);
                    n = 0;
                    all = c | u | dn;
                    ho  = (d > 0) ? dn : u;
                    ahd = (d > 0) ? any_above(all, f) : any_below(all, f);
                    aho = (d > 0) ? any_below(all, f) : any_above(all, f);
                    if (ahd) phase = 1;
                    else if (ho[f]) begin d = -d; phase = 2; end
                    else if (aho) begin d = -d; phase = 1; end
                    else begin d = 0; phase = 3; end
                end
            endcase
        end
        m_floor = f;
    endtask

    task automatic run_round(input logic [7:1] c, input logic [7:1] u, input logic [7:1] d,
                             input bit timed, input int hold, input bit freeze);
        int c0, fb, last, seen, frz_floor;
        bit hm, done;
        logic [7:0] uv, dv;
        @(negedge clk);
        carButton  = c;
        upButton   = u;
        downButton = d;
        c0 = cyc;
        fb = m_floor;
        uv = {u, 1'b0};
        dv = {d, 1'b0};
        model_round({c, 1'b0}, uv, dv, c0 + (freeze ? 10 : 0), timed);
        #1;
        check("floor_button", int'(currentFloorButton), int'({uv[fb], dv[fb]}));
        last = c0;
        seen = 0;
        done = 1'b0;
        frz_floor = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (freeze && cyc == c0 + 2) begin
                enable = 1'b0;
                frz_floor = int'(currentFloor);
            end
            if (freeze && cyc == c0 + 12) begin
                check("freeze_floor", int'(currentFloor), frz_floor);
                check("freeze_moving", int'(moving), 1);
                enable = 1'b1;
            end
            if (servedValid) begin
                carButton[servedFloor] = 1'b0;
                if (servedDirection == 2'b10) upButton[servedFloor] = 1'b0;
                else if (servedDirection == 2'b01) downButton[servedFloor] = 1'b0;
                seen++;
                last = cyc;
                if (hold > 0 && seen == 1) begin
                    doorState = 1'b1;
                    hm = 1'b0;
                    repeat (hold) begin
                        @(negedge clk);
                        if (moving) hm = 1'b1;
                    end
                    check("hold_open_moving", int'(hm), 0);
                    doorState = 1'b0;
                    @(negedge clk);
                    check("close_to_moving", int'(moving), 1);
                    last = cyc;
                end
            end
            if (sb.size() == 0 && cyc >= last + MD + 2) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL round_timeout: %0d served events still pending, expected 0", sb.size());
            sb.delete();
        end
        check("end_floor", int'(currentFloor), m_floor);
        check("end_dir", int'(currentDirection), 0);
        check("end_moving", int'(moving), 0);
    endtask

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (servedValid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL served_unexpected: got floor %0d dir %b at cycle %0d, expected none",
                             servedFloor, servedDirection, cyc);
                end else begin
                    e = sb.pop_front();
                    if (int'(servedFloor) != e.floor || servedDirection != enc(e.dir) ||
                        (e.timed && cyc != e.cyc)) begin
                        n_fail++;
                        $display("FAIL served: got floor %0d dir %b cycle %0d, expected floor %0d dir %b cycle %0d%s",
                                 servedFloor, servedDirection, cyc, e.floor, enc(e.dir), e.cyc,
                                 e.timed ? "" : " (cycle not checked)");
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:1] rc, ru, rd;
        bit ok;
        reset      = 1'b1;
        enable     = 1'b1;
        doorState  = 1'b0;
        upButton   = '0;
        downButton = '0;
        carButton  = '0;
        repeat (2) @(negedge clk);
        check("rst_floor", int'(currentFloor), 1);
        check("rst_dir", int'(currentDirection), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_served_valid", int'(servedValid), 0);
        check("rst_served_floor", int'(servedFloor), 1);
        check("rst_served_dir", int'(servedDirection), 0);
        reset = 1'b0;

        run_round(7'b0001000, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        run_round(7'b0000000, 7'b0010000, 7'b0100000, 1'b1, 0, 1'b0);
        run_round(7'b1000000, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        run_round(7'b1000000, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        run_round(7'b0000001, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        run_round(7'b0000001, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        run_round(7'b0001000, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        run_round(7'b0001010, 7'b0000000, 7'b0000000, 1'b0, 20, 1'b0);
        run_round(7'b1000000, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b1);

        // Asynchronous reset while travelling from floor 3 towards 4.
        run_round(7'b0000001, 7'b0000000, 7'b0000000, 1'b1, 0, 1'b0);
        @(negedge clk);
        carButton = 7'b0100000;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (currentFloor == 3'd3) ok = 1'b1;
        end
        check("reach_floor3", int'(ok), 1);
        repeat (3) @(negedge clk);
        check("pre_reset_moving", int'(moving), 1);
        #2 reset = 1'b1;
        #1;
        check("midtravel_rst_floor", int'(currentFloor), 1);
        check("midtravel_rst_dir", int'(currentDirection), 0);
        check("midtravel_rst_moving", int'(moving), 0);
        carButton = '0;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_floor = 1;

        for (int r = 0; r < 12; r++) begin
            rc = 7'($urandom) & 7'($urandom);
            ru = 7'($urandom) & 7'($urandom) & 7'b0111111;
            rd = 7'($urandom) & 7'($urandom) & 7'b1111110;
            run_round(rc, ru, rd, 1'b1, 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
